// File: rtl/gpio_seq_ctrl.sv
// GPIO pin sequencer: buffers output steps in a FIFO and plays them onto the pads,
// holding each for a programmed count and sampling the synchronised pad inputs at each step end.
module gpio_seq_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int HOLD_W     = 8
) (
    input  logic                    pclk,
    input  logic                    n_p_reset,
    input  logic                    step_valid,
    output logic                    step_ready,
    input  logic [DATA_WIDTH-1:0]   step_out,
    input  logic [DATA_WIDTH-1:0]   step_oe_n,
    input  logic [HOLD_W-1:0]       step_hold,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [DATA_WIDTH-1:0]   n_gpio_pin_oe,
    output logic [DATA_WIDTH-1:0]   gpio_pin_out,
    input  logic [DATA_WIDTH-1:0]   gpio_pin_in,
    output logic [DATA_WIDTH-1:0]   capture,
    output logic                    capture_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem_out  [DEPTH];
    logic [DATA_WIDTH-1:0] mem_oe_n [DEPTH];
    logic [HOLD_W-1:0]     mem_hold [DEPTH];

    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           level;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [DATA_WIDTH-1:0] sync_p0, sync_in;
    logic                  fifo_empty, fifo_full;
    logic                  push, pop, done_set, cap_set;

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LVL_FULL);
    assign step_ready = !fifo_full;
    assign fifo_level = level;
    assign busy       = (state == ST_RUN);
    // abort wins over everything, so a push in the abort cycle is dropped
    assign push       = step_valid && !fifo_full && !abort;

    // Pad input synchroniser
    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
            sync_p0 <= '0;
            sync_in <= '0;
        end else begin
            sync_p0 <= gpio_pin_in;
            sync_in <= sync_p0;
        end
    end

    // Step FIFO storage
    always_ff @(posedge pclk) begin
        if (push) begin
            mem_out[wr_ptr]  <= step_out;
            mem_oe_n[wr_ptr] <= step_oe_n;
            mem_hold[wr_ptr] <= step_hold;
        end
    end

    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sequencer FSM
    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        done_set  = 1'b0;
        cap_set   = 1'b0;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (!fifo_empty) begin
                            pop       = 1'b1;
                            state_nxt = ST_RUN;
                        end else begin
                            done_set  = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (hold_cnt == '0) begin
                        cap_set = 1'b1;
                        if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            done_set  = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Pin drive, hold counter and capture
    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
            n_gpio_pin_oe <= '1;
            gpio_pin_out  <= '0;
            hold_cnt      <= '0;
            done          <= 1'b0;
            capture_valid <= 1'b0;
            capture       <= '0;
        end else begin
            done          <= done_set;
            capture_valid <= cap_set;
            if (cap_set)
                capture <= sync_in;
            if (abort) begin
                n_gpio_pin_oe <= '1;
                gpio_pin_out  <= '0;
                hold_cnt      <= '0;
            end else if (pop) begin
                gpio_pin_out  <= mem_out[rd_ptr];
                n_gpio_pin_oe <= mem_oe_n[rd_ptr];
                hold_cnt      <= mem_hold[rd_ptr];
            end else if (state == ST_RUN && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gpio_seq_ctrl.sv
// Bench for gpio_seq_ctrl: directed scenarios plus random traffic, every cycle compared
// against a queue-based model of the step player.
module tb_gpio_seq_ctrl;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int HW    = 8;

    logic          pclk;
    logic          n_p_reset;
    logic          step_valid;
    logic          step_ready;
    logic [DW-1:0] step_out;
    logic [DW-1:0] step_oe_n;
    logic [HW-1:0] step_hold;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [3:0]    fifo_level;
    logic [DW-1:0] n_gpio_pin_oe;
    logic [DW-1:0] gpio_pin_out;
    logic [DW-1:0] gpio_pin_in;
    logic [DW-1:0] capture;
    logic          capture_valid;

    logic          loopback;
    logic [DW-1:0] pin_rand;

    assign gpio_pin_in = loopback ? gpio_pin_out : pin_rand;

    gpio_seq_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .HOLD_W(HW)) dut (
        .pclk          (pclk),
        .n_p_reset     (n_p_reset),
        .step_valid    (step_valid),
        .step_ready    (step_ready),
        .step_out      (step_out),
        .step_oe_n     (step_oe_n),
        .step_hold     (step_hold),
        .start         (start),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .fifo_level    (fifo_level),
        .n_gpio_pin_oe (n_gpio_pin_oe),
        .gpio_pin_out  (gpio_pin_out),
        .gpio_pin_in   (gpio_pin_in),
        .capture       (capture),
        .capture_valid (capture_valid)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic [DW-1:0] o;
        logic [DW-1:0] oe;
        int            hold;
    } step_t;

    step_t         q[$];
    logic          m_busy, m_done, m_cv;
    logic [DW-1:0] m_out, m_oe, m_cap, m_s1, m_s2;
    int            m_remain;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_busy = 0; m_done = 0; m_cv = 0;
        m_out = '0; m_oe = '1; m_cap = '0; m_s1 = '0; m_s2 = '0;
        m_remain = 0;
    endtask

    task automatic load_head();
        step_t e;
        e = q.pop_front();
        m_out    = e.o;
        m_oe     = e.oe;
        m_remain = e.hold + 1;
    endtask

    // One clock of the player, from the inputs currently applied.
    task automatic model_step();
        logic [DW-1:0] pin_s;
        bit            acc;
        step_t         e;
        pin_s  = loopback ? m_out : pin_rand;
        acc    = step_valid && (q.size() < DEPTH) && !abort;
        m_done = 0;
        m_cv   = 0;
        if (abort) begin
            q.delete();
            m_busy = 0;
            m_out  = '0;
            m_oe   = '1;
        end else begin
            if (!m_busy) begin
                if (start) begin
                    if (q.size() > 0) begin
                        load_head();
                        m_busy = 1;
                    end else begin
                        m_done = 1;
                    end
                end
            end else if (m_remain == 1) begin
                m_cap = m_s2;
                m_cv  = 1;
                if (q.size() > 0) load_head();
                else begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else begin
                m_remain--;
            end
            if (acc) begin
                e.o = step_out; e.oe = step_oe_n; e.hold = int'(step_hold);
                q.push_back(e);
            end
        end
        m_s2 = m_s1;
        m_s1 = pin_s;
    endtask

    task automatic compare_all();
        chk("n_gpio_pin_oe", 32'(n_gpio_pin_oe), 32'(m_oe));
        chk("gpio_pin_out", 32'(gpio_pin_out), 32'(m_out));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("capture_valid", 32'(capture_valid), 32'(m_cv));
        chk("capture", 32'(capture), 32'(m_cap));
        chk("fifo_level", 32'(fifo_level), q.size());
        chk("step_ready", 32'(step_ready), 32'(q.size() < DEPTH));
    endtask

    task automatic tick(input logic v, input logic [DW-1:0] o, input logic [DW-1:0] oe,
                        input logic [HW-1:0] h, input logic s, input logic a);
        step_valid = v; step_out = o; step_oe_n = oe; step_hold = h;
        start = s; abort = a;
        pin_rand = DW'($urandom);
        model_step();
        @(negedge pclk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [DW-1:0] o, input logic [DW-1:0] oe, input logic [HW-1:0] h);
        tick(1'b1, o, oe, h, 1'b0, 1'b0);
    endtask

    task automatic go();
        tick(1'b0, '0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic mid_reset();
        step_valid = 0; start = 0; abort = 0;
        #2 n_p_reset = 1'b0;
        #1;
        chk("rst_oe", 32'(n_gpio_pin_oe), 32'h0000_FFFF);
        chk("rst_out", 32'(gpio_pin_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_level", 32'(fifo_level), 32'h0);
        chk("rst_ready", 32'(step_ready), 32'h1);
        chk("rst_capture", 32'(capture), 32'h0);
        model_reset();
        @(negedge pclk);
        compare_all();
        n_p_reset = 1'b1;
    endtask

    initial begin
        n_p_reset = 1'b0;
        step_valid = 0; step_out = '0; step_oe_n = '0; step_hold = '0;
        start = 0; abort = 0; loopback = 0; pin_rand = '0;
        model_reset();
        repeat (2) @(negedge pclk);
        compare_all();
        n_p_reset = 1'b1;

        // basic playback
        push(16'h00A5, 16'hFF00, 8'd3);
        go();
        idle(6);

        // back-to-back with pins looped back
        loopback = 1;
        push(16'h1111, 16'h0000, 8'd0);
        push(16'h2222, 16'h00F0, 8'd1);
        push(16'h3333, 16'h0F00, 8'd2);
        go();
        idle(10);
        loopback = 0;

        // fill past full, flush, then start on empty
        for (int i = 0; i < DEPTH + 1; i++) push(16'(i * 16'h0101), 16'(~i), 8'(i % 3));
        tick(1'b0, '0, '0, '0, 1'b0, 1'b1);
        go();
        idle(3);

        // abort during step 2 of 5, with a push in the abort cycle
        for (int i = 0; i < 5; i++) push(16'(16'hA000 + i), 16'h00FF, 8'd3);
        go();
        idle(5);
        tick(1'b1, 16'hDEAD, 16'h0000, 8'd1, 1'b0, 1'b1);
        idle(4);

        // push while running, start while busy
        push(16'h0F0F, 16'hF0F0, 8'd4);
        go();
        idle(2);
        tick(1'b1, 16'h5A5A, 16'h1234, 8'd2, 1'b1, 1'b0);
        idle(2);
        go();
        idle(12);

        // longest hold
        push(16'hBEEF, 16'h0001, 8'hFF);
        go();
        idle(260);

        // random traffic with a mid-run reset
        for (int i = 0; i < 1500; i++) begin
            logic [HW-1:0] h;
            if (i % 200 == 0) loopback = ~loopback;
            h = ($urandom_range(0, 9) == 0) ? HW'($urandom_range(0, 255)) : HW'($urandom_range(0, 3));
            if (i == 700) begin
                push(16'h7777, 16'h0000, 8'd20);
                go();
                idle(3);
                mid_reset();
            end
            tick(1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom), h,
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 39) == 0));
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
